shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Multi-cycle shift sequencer: applies a requested shift/rotate by an N-bit amount.
//   Iterates a single 1-bit shift stage, one step per clock (LSL, LSR, ASR, ROL, ROR).
//   Sits between a command producer and result consumer; valid/ready handshake both sides.
// PARAMETERS
//   WIDTH  8  data width in bits; must be a power of 2, >= 2
//   AMT_W  4  shift-amount field width; amounts 0..2^AMT_W-1
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      async active-low reset
//   in_valid   in   1      command valid
//   in_ready   out  1      sequencer can accept a command
//   in_op      in   3      0=LSL 1=LSR 2=ASR 3=ROL 4=ROR; 5..7 illegal
//   in_amt     in   AMT_W  shift amount
//   in_data    in   WIDTH  operand; ASR treats it as signed
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  result
//   out_err    out  1      result was an illegal-op command; qualified by out_valid
//   busy       out  1      FSM not in IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): FSM=IDLE; in_ready=1, out_valid=0, out_data=0, out_err=0, busy=0.
//   FSM states IDLE, SHIFT, DONE:
//   - IDLE: in_ready=1. in_valid&in_ready latches op/amt/data.
//     Then -> SHIFT if effective amt>0 and op legal; else -> DONE.
//   - SHIFT: one 1-bit step per cycle on the data reg; remaining count decrements.
//     -> DONE on the cycle the last step is applied.
//   - DONE: out_valid=1; out_data/out_err held stable until out_valid&out_ready -> IDLE.
//   - in_ready=0 in SHIFT and DONE; no command overlap, no bypass.
//   1-bit steps:
//   - LSL: {d[W-2:0],0}. LSR: {0,d[W-1:1]}. ASR: {d[W-1],d[W-1:1]}.
//   - ROL: {d[W-2:0],d[W-1]}. ROR: {d[0],d[W-1:1]}.
//   Effective amount:
//   - rotates: amt mod WIDTH (low log2(WIDTH) bits).
//   - shifts: full amt; amt >= WIDTH gives all zeros (LSL/LSR) or all sign bits (ASR).
//   Latency, accept edge to out_valid: 1+eff_amt cycles.
//   - eff_amt=0: out_valid 1 cycle after accept; out_data=in_data.
//   Illegal op: no shifting; DONE with out_data=in_data, out_err=1 (out_err=0 for legal ops).
//   out_ready may be held high in IDLE/SHIFT; it has no effect there.
//   DONE with out_ready=1: result consumed that cycle; next command accepted the cycle after.
//   rst_n low mid-SHIFT or mid-DONE: command discarded, all outputs to reset values at once.
//   in_data/in_op/in_amt are don't-care when in_valid=0 or in_ready=0.
// CONFIGURATION
//   SHIFT_SEQ_FASTPATH_EN defined:
//   - LSL/LSR/ASR with amt >= WIDTH skip SHIFT; -> DONE on the cycle after accept.
//   - Result is the saturated value: zeros for LSL/LSR, replicated sign bit for ASR.
//   - Latency becomes 1+min(amt,...): amt >= WIDTH takes 1 cycle.
//   Undefined: those commands iterate all amt steps; final data value is identical.
//   Rotates are unaffected either way.
// TESTING
//   1. Reset: rst_n=0 -> in_ready=1, out_valid=0, out_data=0, busy=0.
//   2. LSL: op=0, amt=3, data=8'h81 -> out_data=8'h08 after 4 cycles; in_ready=0 meanwhile.
//   3. ASR: op=2, amt=2, data=8'h90 -> 8'hE4. ROR: op=4, amt=9, data=8'h01 -> 8'h80 (eff 1).
//   4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable; new in_valid ignored.
//      Then out_ready=1 -> IDLE; next command accepted the following cycle.
//   5. Illegal op=6, data=8'h5A -> out_data=8'h5A, out_err=1 after 1 cycle.
//      amt=0 with op=1 -> out_data=in_data, out_err=0.
//   6. LSR amt=12, data=8'hFF -> 8'h00.
//      Latency 1 cycle with SHIFT_SEQ_FASTPATH_EN, 13 cycles without.
//      Assert rst_n=0 mid-SHIFT -> outputs reset immediately, no result emitted.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: one 1-bit step per clock, valid/ready on both sides.
// Optional macro SHIFT_SEQ_FASTPATH_EN: logical/arithmetic shifts by >= WIDTH skip iteration.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [AMT_W-1:0] ROT_MASK = AMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    state_t           w_state_nxt;
    logic [2:0]       w_op_nxt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_err_nxt;
    logic             w_legal;
    logic             w_rot;
    logic [AMT_W-1:0] w_eff_amt;
    logic             w_fast;

    function automatic logic [WIDTH-1:0] f_step(input logic [2:0] op, input logic [WIDTH-1:0] d);
        case (op)
            OP_LSL:  f_step = {d[WIDTH-2:0], 1'b0};
            OP_LSR:  f_step = {1'b0, d[WIDTH-1:1]};
            OP_ASR:  f_step = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  f_step = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  f_step = {d[0], d[WIDTH-1:1]};
            default: f_step = d;
        endcase
    endfunction

    assign w_legal   = (in_op <= OP_ROR);
    assign w_rot     = (in_op == OP_ROL) || (in_op == OP_ROR);
    // Rotates only need the amount modulo WIDTH; shifts keep the full amount.
    assign w_eff_amt = w_rot ? (in_amt & ROT_MASK) : in_amt;

`ifdef SHIFT_SEQ_FASTPATH_EN
    logic w_big;
    assign w_big  = (int'(in_amt) >= WIDTH);
    assign w_fast = w_legal && !w_rot && w_big;
`else
    assign w_fast = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_op_nxt   = in_op;
                    w_err_nxt  = !w_legal;
                    w_data_nxt = in_data;
                    w_cnt_nxt  = w_eff_amt;
                    if (w_fast) begin
                        w_data_nxt  = (in_op == OP_ASR) ? {WIDTH{in_data[WIDTH-1]}} : '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else if (w_legal && (w_eff_amt != '0)) begin
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                w_data_nxt = f_step(r_op, r_data);
                w_cnt_nxt  = r_cnt - AMT_W'(1);
                if (r_cnt <= AMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_data;
    assign out_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: vector table plus backpressure and mid-command reset sequences.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;
`ifdef SHIFT_SEQ_FASTPATH_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             busy;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp_data;
        logic             exp_err;
        int               exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic scramble_inputs();
        in_op   = 3'($urandom_range(0, 7));
        in_amt  = AMT_W'($urandom_range(0, 15));
        in_data = WIDTH'($urandom_range(0, 255));
    endtask

    // Counts falling edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat, output logic ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < 40 && !ok) begin
            @(negedge clk);
            lat++;
            if (out_valid) ok = 1'b1;
            else check("in_ready_low_while_busy", in_ready, 1'b0);
        end
        if (!ok) check("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [AMT_W-1:0] amt,
                            input logic [WIDTH-1:0] data);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_op    = op;
        in_amt   = amt;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_consume_out_valid", out_valid, 1'b0);
        check("after_consume_in_ready", in_ready, 1'b1);
        check("after_consume_busy", busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_err"}, out_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int   lat;
        logic ok;

        vecs[0]  = '{3'd0, 4'd3,  8'h81, 8'h08, 1'b0, 4};
        vecs[1]  = '{3'd2, 4'd2,  8'h90, 8'hE4, 1'b0, 3};
        vecs[2]  = '{3'd4, 4'd9,  8'h01, 8'h80, 1'b0, 2};
        vecs[3]  = '{3'd6, 4'd5,  8'h5A, 8'h5A, 1'b1, 1};
        vecs[4]  = '{3'd1, 4'd0,  8'h3C, 8'h3C, 1'b0, 1};
        vecs[5]  = '{3'd1, 4'd12, 8'hFF, 8'h00, 1'b0, FAST ? 1 : 13};
        vecs[6]  = '{3'd3, 4'd3,  8'hB1, 8'h8D, 1'b0, 4};
        vecs[7]  = '{3'd2, 4'd15, 8'h80, 8'hFF, 1'b0, FAST ? 1 : 16};
        vecs[8]  = '{3'd0, 4'd8,  8'hFF, 8'h00, 1'b0, FAST ? 1 : 9};
        vecs[9]  = '{3'd3, 4'd8,  8'h5A, 8'h5A, 1'b0, 1};
        vecs[10] = '{3'd2, 4'd7,  8'h7F, 8'h00, 1'b0, 8};
        vecs[11] = '{3'd4, 4'd15, 8'h96, 8'h2D, 1'b0, 8};
        vecs[12] = '{3'd5, 4'd0,  8'h11, 8'h11, 1'b1, 1};
        vecs[13] = '{3'd1, 4'd4,  8'hA5, 8'h0A, 1'b0, 5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble_inputs();
        #1;
        check_reset_outputs("reset");
        #22;
        rst_n = 1'b1;

        // Odd vectors hold out_ready high throughout; it must not disturb IDLE/SHIFT.
        for (int i = 0; i < 14; i++) begin
            out_ready = (i % 2 == 1);
            send_cmd(vecs[i].op, vecs[i].amt, vecs[i].data);
            wait_done(lat, ok);
            if (ok) begin
                check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
                check($sformatf("v%0d_err", i), out_err, vecs[i].exp_err);
                check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
                check($sformatf("v%0d_busy", i), busy, 1'b1);
            end
            consume();
        end

        // Backpressure: result held through 5 stalled cycles while a new command waits.
        send_cmd(3'd0, 4'd1, 8'h01);
        wait_done(lat, ok);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_op    = 3'd1;
            in_amt   = 4'd1;
            in_data  = 8'h80;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, 8'h02);
            check("bp_out_err", out_err, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        check("bp_next_accepted_busy", busy, 1'b1);
        wait_done(lat, ok);
        check("bp_next_data", out_data, 8'h40);
        check("bp_next_lat", lat, 2);
        consume();

        // Reset in the middle of SHIFT discards the command.
        send_cmd(3'd3, 4'd7, 8'h01);
        repeat (3) @(negedge clk);
        check("mid_shift_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_shift");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("rst_mid_shift_no_result", out_valid, 1'b0);
        end

        // Reset while a result sits in DONE.
        send_cmd(3'd0, 4'd2, 8'h21);
        wait_done(lat, ok);
        check("mid_done_data", out_data, 8'h84);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_done");
        @(negedge clk);
        rst_n = 1'b1;

        send_cmd(3'd2, 4'd1, 8'h82);
        wait_done(lat, ok);
        check("post_reset_data", out_data, 8'hC1);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
